// File: rtl/w_bus_arbiter.sv
// Round-robin owner of the shared 8-bit W operand bus: grants one requester a
// burst of beats, registers its data onto W, and releases on LAST, abandon or MAXBEAT.
module w_bus_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = 8,
    parameter int unsigned MAXBEAT = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      REQ,
    input  logic [NREQ-1:0]      LAST,
    input  logic [NREQ*DW-1:0]   DIN,
    output logic [NREQ-1:0]      GNT,
    output logic [DW-1:0]        W,
    output logic                 WVALID,
    output logic                 BUSY,
    output logic                 OVR
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(MAXBEAT) + 1;

    typedef enum logic {IDLE, OWN} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [DW-1:0]     w_q, w_d;
    logic              wvalid_q, wvalid_d;
    logic              ovr_q, ovr_d;

    logic [DW-1:0]     din_a [NREQ];
    logic [PW-1:0]     pick_c;
    logic              found_c;
    logic [PW:0]       idx_c;
    logic [PW-1:0]     owner_inc_c;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            din_a[i] = DIN[i*DW +: DW];
        end
    end

    // First requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        pick_c  = ptr_q;
        found_c = 1'b0;
        idx_c   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx_c = {1'b0, ptr_q} + (PW+1)'(k);
            if (idx_c >= (PW+1)'(NREQ)) begin
                idx_c = idx_c - (PW+1)'(NREQ);
            end
            if (!found_c && REQ[idx_c[PW-1:0]]) begin
                pick_c  = idx_c[PW-1:0];
                found_c = 1'b1;
            end
        end
    end

    assign owner_inc_c = (owner_q == PW'(NREQ-1)) ? '0 : owner_q + PW'(1);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        w_d      = w_q;
        wvalid_d = 1'b0;
        ovr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (found_c) begin
                    state_d = OWN;
                    owner_d = pick_c;
                    cnt_d   = '0;
                    gnt_d   = NREQ'(1) << pick_c;
                end
            end
            OWN: begin
                if (REQ[owner_q]) begin
                    w_d      = din_a[owner_q];
                    wvalid_d = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                    if (LAST[owner_q] || (cnt_q == CW'(MAXBEAT-1))) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        ptr_d   = owner_inc_c;
                        ovr_d   = ~LAST[owner_q];
                    end
                end else begin
                    // Owner abandoned the bus: release without a beat.
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = owner_inc_c;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            w_q      <= '0;
            wvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            w_q      <= w_d;
            wvalid_q <= wvalid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign GNT    = gnt_q;
    assign W      = w_q;
    assign WVALID = wvalid_q;
    assign BUSY   = (state_q == OWN);
    assign OVR    = ovr_q;

endmodule

// File: doc/w_bus_arbiter.md
Name: w_bus_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit W operand bus between NREQ requesters.
- Feeds the W input of the gate-level datapath block, which has no flow control of its own.
- Grants the bus to one requester for a burst of beats, then releases it on LAST, on requester abandon, or on a MAXBEAT timeout.
- Registers the winning data onto W with a valid qualifier.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, data width of W and of each requester slice.
- MAXBEAT, 16, maximum beats per grant before forced release (>=1).

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ  input  NREQ  per-requester request; also acts as beat-valid while granted.
- LAST  input  NREQ  per-requester final-beat marker; sampled only with GNT&REQ.
- DIN  input  NREQ*DW  requester data; slice i = DIN[i*DW +: DW].
- GNT  output  NREQ  one-hot grant, registered.
- W  output  DW  shared bus data, registered.
- WVALID  output  1  W carries a beat this cycle.
- BUSY  output  1  high while a grant is held (state OWN).
- OVR  output  1  one-cycle pulse when a grant is force-released by MAXBEAT.

Behaviour:

Reset:
- RST high at an edge overrides every other event, including mid-burst.
- Reset values: GNT=0, W=0, WVALID=0, BUSY=0, OVR=0, state=IDLE, ptr=0, beat count=0.

States: IDLE, OWN.

IDLE:
- If REQ!=0, select the first i with REQ[i]=1, searching ptr, ptr+1, … modulo NREQ.
- Next cycle: GNT=onehot(i), owner=i, count=0, state=OWN, BUSY=1.
- If REQ=0, stay in IDLE; GNT=0.
- Grant latency: REQ seen at edge t gives GNT at t+1.

OWN, with owner o:
- Beat: GNT[o] & REQ[o] in a cycle.
  - Next cycle: W=DIN slice o, WVALID=1.
  - count increments.
  - Data latency is exactly 1 cycle.
- No beat: next cycle WVALID=0 and W holds its previous value.
- Final beat: a beat with LAST[o]=1, or a beat with count==MAXBEAT-1.
  - Next cycle: GNT=0, BUSY=0, state=IDLE, ptr=(o+1) mod NREQ.
  - The final beat's W/WVALID appear in that same cycle.
- Forced release: a final beat caused only by count==MAXBEAT-1 with LAST[o]=0 sets OVR=1 for exactly the next cycle.
  - LAST coincident with the MAXBEAT limit does not pulse OVR.
- Abandon: REQ[o]=0 while granted.
  - No beat; next cycle GNT=0, WVALID=0, state=IDLE, ptr=(o+1) mod NREQ.
- Inputs of non-owners are ignored in OWN. REQ, LAST and DIN of non-owners have no effect.

Bus sharing rules:
- There is always at least one IDLE cycle between successive grants. Minimum grant-to-grant spacing is 2 cycles.
- MAXBEAT=1: every grant is a single beat; OVR pulses unless LAST=1.
- Beat counter width is clog2(MAXBEAT)+1. It never wraps, because release occurs at MAXBEAT-1.
- Invariants:
  - GNT is always 0 or one-hot.
  - WVALID=1 implies that the previous cycle had GNT!=0.
  - OVR=1 implies GNT=0.

Test Plan:
- Reset then REQ=4'b0101, DIN slices 0xA0/0xC2, LAST[0] on the 3rd beat → GNT=0001 at +1; W=0xA0 on 3 consecutive cycles; GNT=0 one cycle; then GNT=0100; ptr=1.
- Fairness: REQ=4'b1111 held, every LAST=1 → grant order 0,2? No: order 0,1,2,3,0, one beat each; an IDLE cycle between each; WVALID duty 50%.
- Timeout: MAXBEAT=16, requester 3 holds REQ with LAST=0 → exactly 16 WVALID beats; OVR=1 for 1 cycle coincident with GNT=0; requester 0 is granted next if requesting.
- Abandon: requester 1 granted, REQ[1] drops after 2 beats → WVALID for 2 cycles only; GNT=0 next cycle; ptr=2; no OVR.
- Reset mid-burst: RST high during beat 5 of requester 2 → following cycle GNT=0, W=0, WVALID=0, BUSY=0; after release, REQ=1111 grants requester 0.
- Non-owner isolation: while requester 0 is granted, toggle REQ/LAST/DIN of 1..3 → W matches only DIN slice 0; the grant length is unaffected.
